datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Single-cycle register-file + ALU datapath.
- Two combinational register reads feed a 3-bit-controlled ALU; the ALU result is written back to the register file on the rising clock edge when write enable is asserted.
- Register file: 4 registers R0–R3. No register is hardwired to zero.
- Sits under the control unit, which drives all addresses, enables and opcodes.

Parameters:
- WORD_SIZE, 32, data width of registers, ALU operands and result.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- RegReadAddr1  in  2  read port 1 address; drives ALU operand A.
- RegReadAddr2  in  2  read port 2 address; drives ALU operand B.
- RegWriteAddr  in  2  write-back destination register.
- RegWriteEnable  in  1  write-back enable.
- ALUControl  in  3  ALU operation select.
- ReadData1  out  WORD_SIZE  register[RegReadAddr1], combinational.
- ReadData2  out  WORD_SIZE  register[RegReadAddr2], combinational.
- ALUResult  out  WORD_SIZE  ALU output, combinational.
- Zero  out  1  high when ALUResult == 0.

Behaviour:
- Reset and power-up state: identical constants. Rst high at a rising Clk edge loads them; the same values are also register initial values, so the block is usable without asserting Rst.
  - R0 = 0
  - R1 = 0
  - R2 = all ones (-1)
  - R3 = 1
- Rst has priority over RegWriteEnable in the same cycle.
- Reads are asynchronous, with no write-to-read bypass. A read of the register being written returns the old value until after the edge.
- Write: at a rising Clk edge with RegWriteEnable=1 and Rst=0, register[RegWriteAddr] <= ALUResult. With enable low, all registers hold.
- Any register, R0 included, may be written.
- Latency: operands to ALUResult is combinational (0 cycles); the written value is visible on read ports 1 cycle later.
- Reading the same address on both ports is legal.
- ALU, with A = ReadData1, B = ReadData2:
  - 000 ADD: A + B, modulo 2^WORD_SIZE (wraps).
  - 001 SUB: A - B, modulo 2^WORD_SIZE (wraps).
  - 010 AND: A & B.
  - 011 XOR: A ^ B.
  - 100 OR: A | B.
  - 101 SLT: 1 if signed A < signed B, else 0 (zero-extended).
  - 110 SLL: A << B[4:0].
  - 111 SRL: A >> B[4:0], logical.
- Zero is derived from ALUResult for every opcode.
- No X propagation from unused paths: outputs are fully defined for all input combinations after init.

Optional Feature:
- Macro: DATAPATH_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit, combinational).
  - For ADD: high when A and B have the same sign and the result sign differs.
  - For SUB: high when A and B signs differ and the result sign differs from A.
  - Low for all other opcodes.
  - Overflow never blocks the write-back.
- Undefined: port absent, no overflow logic; all other behaviour unchanged.

Test Plan:
1. Init, no reset, RegWriteEnable=0: read ports 0..3 -> 0, 0, FFFFFFFF, 00000001; no register changes over several clocks.
2. R1 <- R0 XOR R0: Addr1=0, Addr2=0, ALUControl=011, WriteAddr=1, WE=1, one edge -> ALUResult=0, Zero=1, R1=0.
3. R0 <- R2 + R1: Addr1=2, Addr2=1, op=000, WriteAddr=0, WE=1 -> R0=FFFFFFFF.
4. R2 <- R1 - R3 then R3 <- R0 + R3:
   - op=001 -> R2=FFFFFFFF.
   - Then Addr1=0, Addr2=3, op=000, WriteAddr=3 -> ALUResult=0 (wrap), Zero=1, R3=0.
5. Reset and enable rules:
   - Rst=1 together with WE=1, WriteAddr=2, for one edge -> R2 returns to FFFFFFFF (reset wins); all registers at reset constants.
   - WE=0 with a live ALU result -> no register changes.
6. Opcode sweep with A=80000000, B=00000001 -> results:
   - 010 AND: 0
   - 100 OR: 80000001
   - 101 SLT: 1
   - 110 SLL: 0
   - 111 SRL: 40000000
   - With DATAPATH_OVF_EN: A=7FFFFFFF, B=1, op=000 -> Overflow=1.

Source files
------------

// File: rtl/datapath.sv
// ============================================================================
// datapath -- single-cycle register-file + ALU datapath
//
// Four general-purpose registers R0..R3 with two asynchronous read ports. The
// ALU combines the two read values under a 3-bit opcode. When write-enable is
// high, the ALU result is written back into the register file on the rising
// clock edge. Registers power up with the same constants that reset loads, so
// the block is usable without ever asserting Rst.
//
// Optional feature:
//   DATAPATH_OVF_EN -- when defined, adds a combinational Overflow output that
//                      flags signed overflow on ADD and SUB.
// ============================================================================
module datapath #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [1:0]           RegReadAddr1,
    input  logic [1:0]           RegReadAddr2,
    input  logic [1:0]           RegWriteAddr,
    input  logic                 RegWriteEnable,
    input  logic [2:0]           ALUControl,
    output logic [WORD_SIZE-1:0] ReadData1,
    output logic [WORD_SIZE-1:0] ReadData2,
    output logic [WORD_SIZE-1:0] ALUResult,
    output logic                 Zero
`ifdef DATAPATH_OVF_EN
    ,
    output logic                 Overflow
`endif
);

    // ALU operation encoding as seen on ALUControl
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_XOR = 3'b011,
        ALU_OR  = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } aluOp_t;

    // Constants loaded both at power-up and by a synchronous reset
    localparam logic [WORD_SIZE-1:0] INIT_R0 = '0;
    localparam logic [WORD_SIZE-1:0] INIT_R1 = '0;
    localparam logic [WORD_SIZE-1:0] INIT_R2 = '1;
    localparam logic [WORD_SIZE-1:0] INIT_R3 = WORD_SIZE'(1);

    localparam int MSB = WORD_SIZE - 1;

    // Register file storage; the initializer gives the power-up state
    logic [WORD_SIZE-1:0] regFile [4] = '{INIT_R0, INIT_R1, INIT_R2, INIT_R3};

    logic [WORD_SIZE-1:0] operandA;
    logic [WORD_SIZE-1:0] operandB;
    logic [WORD_SIZE-1:0] sumResult;
    logic [WORD_SIZE-1:0] diffResult;
    logic                 lessThan;
    logic [4:0]           shiftAmount;
    aluOp_t               aluOp;

    // Asynchronous reads: a register being written shows its old value until the edge
    assign ReadData1 = regFile[RegReadAddr1];
    assign ReadData2 = regFile[RegReadAddr2];

    assign operandA    = ReadData1;
    assign operandB    = ReadData2;
    assign aluOp       = aluOp_t'(ALUControl);
    assign sumResult   = operandA + operandB;
    assign diffResult  = operandA - operandB;
    assign lessThan    = $signed(operandA) < $signed(operandB);
    assign shiftAmount = operandB[4:0];

    // ALU result selection; every opcode produces a defined value
    always_comb begin
        ALUResult = '0;
        unique case (aluOp)
            ALU_ADD: ALUResult = sumResult;
            ALU_SUB: ALUResult = diffResult;
            ALU_AND: ALUResult = operandA & operandB;
            ALU_XOR: ALUResult = operandA ^ operandB;
            ALU_OR:  ALUResult = operandA | operandB;
            ALU_SLT: ALUResult = {{(WORD_SIZE-1){1'b0}}, lessThan};
            ALU_SLL: ALUResult = operandA << shiftAmount;
            ALU_SRL: ALUResult = operandA >> shiftAmount;
            default: ALUResult = '0;
        endcase
    end

    assign Zero = (ALUResult == '0);

`ifdef DATAPATH_OVF_EN
    // Signed overflow: only ADD and SUB can overflow; it never gates write-back
    always_comb begin
        Overflow = 1'b0;
        if (aluOp == ALU_ADD) begin
            Overflow = (operandA[MSB] == operandB[MSB]) && (sumResult[MSB] != operandA[MSB]);
        end else if (aluOp == ALU_SUB) begin
            Overflow = (operandA[MSB] != operandB[MSB]) && (diffResult[MSB] != operandA[MSB]);
        end
    end
`endif

    // Register update: reset reloads the constants and takes priority over write-back
    always_ff @(posedge Clk) begin
        if (Rst) begin
            regFile[0] <= INIT_R0;
            regFile[1] <= INIT_R1;
            regFile[2] <= INIT_R2;
            regFile[3] <= INIT_R3;
        end else if (RegWriteEnable) begin
            regFile[RegWriteAddr] <= ALUResult;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// ============================================================================
// tb_datapath -- self-checking bench for datapath (WORD_SIZE = 32)
//
// Directed scenarios from the block's test plan followed by a randomized run
// checked against a behavioural register-file/ALU model. Define
// DATAPATH_OVF_EN to also exercise the Overflow output.
// ============================================================================
module tb_datapath;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [1:0]  RegReadAddr1 = 2'd0;
    logic [1:0]  RegReadAddr2 = 2'd0;
    logic [1:0]  RegWriteAddr = 2'd0;
    logic        RegWriteEnable = 1'b0;
    logic [2:0]  ALUControl = 3'd0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] ALUResult;
    logic        Zero;
`ifdef DATAPATH_OVF_EN
    logic        Overflow;
`endif

    int passCount  = 0;
    int totalCount = 0;

    logic [31:0] initVals [4] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    logic [31:0] model    [4];

    datapath #(.WORD_SIZE(32)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .RegReadAddr1   (RegReadAddr1),
        .RegReadAddr2   (RegReadAddr2),
        .RegWriteAddr   (RegWriteAddr),
        .RegWriteEnable (RegWriteEnable),
        .ALUControl     (ALUControl),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .ALUResult      (ALUResult),
        .Zero           (Zero)
`ifdef DATAPATH_OVF_EN
        ,
        .Overflow       (Overflow)
`endif
    );

    // Free-running clock, period 10
    always #5 Clk = ~Clk;

    // Reference ALU computed from the operation definitions with plain arithmetic
    function automatic logic [31:0] aluRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        int unsigned sh = int'(b % 32);
        case (op)
            3'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            3'd1: return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            3'd2: return a & b;
            3'd3: return a ^ b;
            3'd4: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
            default: return 32'(64'(a) / (64'd1 << sh));
        endcase
    endfunction

    // Reference overflow: does the true signed result fall outside 32-bit range
    function automatic logic ovfRef(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint r;
        if (op == 3'd0) r = sa + sb;
        else if (op == 3'd1) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic applyStimulus(input logic [1:0] a1, input logic [1:0] a2, input logic [2:0] op,
                                 input logic [1:0] wa, input logic we, input logic rst);
        RegReadAddr1   = a1;
        RegReadAddr2   = a2;
        ALUControl     = op;
        RegWriteAddr   = wa;
        RegWriteEnable = we;
        Rst            = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Power-up contents without reset, held across several idle clocks
    task automatic test_reset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            for (int a = 0; a < 4; a++) begin
                applyStimulus(2'(a), 2'(3 - a), 3'd0, 2'(a), 1'b0, 1'b0);
                totalCount++;
                if (ReadData1 !== initVals[a]) $display("[TB] FAIL init_rd1 R%0d: got %h expected %h", a, ReadData1, initVals[a]);
                else passCount++;
                totalCount++;
                if (ReadData2 !== initVals[3 - a]) $display("[TB] FAIL init_rd2 R%0d: got %h expected %h", 3 - a, ReadData2, initVals[3 - a]);
                else passCount++;
            end
            tick();
        end
    endtask

    // R1 <- R0 XOR R0
    task automatic test_xor_write();
        applyStimulus(2'd0, 2'd0, 3'b011, 2'd1, 1'b1, 1'b0);
        totalCount++;
        if (ALUResult !== 32'h0) $display("[TB] FAIL xor_result: got %h expected %h", ALUResult, 32'h0);
        else passCount++;
        totalCount++;
        if (Zero !== 1'b1) $display("[TB] FAIL xor_zero: got %b expected 1", Zero);
        else passCount++;
        tick();
        applyStimulus(2'd1, 2'd1, 3'b000, 2'd0, 1'b0, 1'b0);
        totalCount++;
        if (ReadData1 !== 32'h0) $display("[TB] FAIL xor_r1: got %h expected %h", ReadData1, 32'h0);
        else passCount++;
    endtask

    // R0 <- R2 + R1, R2 <- R1 - R3, R3 <- R0 + R3 (wraps to zero)
    task automatic test_add_sub_chain();
        applyStimulus(2'd2, 2'd1, 3'b000, 2'd0, 1'b1, 1'b0);
        totalCount++;
        if (ALUResult !== 32'hFFFF_FFFF) $display("[TB] FAIL add_r0_result: got %h expected %h", ALUResult, 32'hFFFF_FFFF);
        else passCount++;
        tick();
        applyStimulus(2'd1, 2'd3, 3'b001, 2'd2, 1'b1, 1'b0);
        totalCount++;
        if (ALUResult !== 32'hFFFF_FFFF) $display("[TB] FAIL sub_result: got %h expected %h", ALUResult, 32'hFFFF_FFFF);
        else passCount++;
        tick();
        applyStimulus(2'd0, 2'd3, 3'b000, 2'd3, 1'b1, 1'b0);
        totalCount++;
        if (ReadData1 !== 32'hFFFF_FFFF) $display("[TB] FAIL add_r0_written: got %h expected %h", ReadData1, 32'hFFFF_FFFF);
        else passCount++;
        totalCount++;
        if (ALUResult !== 32'h0) $display("[TB] FAIL wrap_result: got %h expected %h", ALUResult, 32'h0);
        else passCount++;
        totalCount++;
        if (Zero !== 1'b1) $display("[TB] FAIL wrap_zero: got %b expected 1", Zero);
        else passCount++;
        totalCount++;
        if (ReadData2 !== 32'h1) $display("[TB] FAIL no_bypass_r3: got %h expected %h", ReadData2, 32'h1);
        else passCount++;
        tick();
        applyStimulus(2'd2, 2'd3, 3'b000, 2'd0, 1'b0, 1'b0);
        totalCount++;
        if (ReadData1 !== 32'hFFFF_FFFF) $display("[TB] FAIL r2_after_sub: got %h expected %h", ReadData1, 32'hFFFF_FFFF);
        else passCount++;
        totalCount++;
        if (ReadData2 !== 32'h0) $display("[TB] FAIL r3_after_wrap: got %h expected %h", ReadData2, 32'h0);
        else passCount++;
    endtask

    // Reset beats write-enable; write-enable low holds all registers
    task automatic test_reset_priority();
        applyStimulus(2'd0, 2'd0, 3'b000, 2'd2, 1'b1, 1'b1);
        tick();
        for (int a = 0; a < 4; a += 2) begin
            applyStimulus(2'(a), 2'(a + 1), 3'b000, 2'd0, 1'b0, 1'b0);
            totalCount++;
            if (ReadData1 !== initVals[a]) $display("[TB] FAIL rst_rd R%0d: got %h expected %h", a, ReadData1, initVals[a]);
            else passCount++;
            totalCount++;
            if (ReadData2 !== initVals[a + 1]) $display("[TB] FAIL rst_rd R%0d: got %h expected %h", a + 1, ReadData2, initVals[a + 1]);
            else passCount++;
        end
        applyStimulus(2'd2, 2'd3, 3'b001, 2'd0, 1'b0, 1'b0);
        totalCount++;
        if (ALUResult !== 32'hFFFF_FFFE) $display("[TB] FAIL we0_live: got %h expected %h", ALUResult, 32'hFFFF_FFFE);
        else passCount++;
        tick();
        tick();
        applyStimulus(2'd0, 2'd2, 3'b000, 2'd0, 1'b0, 1'b0);
        totalCount++;
        if (ReadData1 !== 32'h0) $display("[TB] FAIL we0_hold_r0: got %h expected %h", ReadData1, 32'h0);
        else passCount++;
        totalCount++;
        if (ReadData2 !== 32'hFFFF_FFFF) $display("[TB] FAIL we0_hold_r2: got %h expected %h", ReadData2, 32'hFFFF_FFFF);
        else passCount++;
    endtask

    // Every opcode with A = 80000000, B = 00000001 (built up from reset contents)
    task automatic test_opcode_sweep();
        logic [31:0] sweepExp [8] = '{32'h8000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001,
                                      32'h8000_0001, 32'h0000_0001, 32'h0000_0000, 32'h4000_0000};
        applyStimulus(2'd2, 2'd3, 3'b111, 2'd0, 1'b1, 1'b0);
        totalCount++;
        if (ALUResult !== 32'h7FFF_FFFF) $display("[TB] FAIL srl_build: got %h expected %h", ALUResult, 32'h7FFF_FFFF);
        else passCount++;
        tick();
        applyStimulus(2'd0, 2'd3, 3'b000, 2'd1, 1'b1, 1'b0);
        totalCount++;
        if (ALUResult !== 32'h8000_0000) $display("[TB] FAIL add_build: got %h expected %h", ALUResult, 32'h8000_0000);
        else passCount++;
`ifdef DATAPATH_OVF_EN
        totalCount++;
        if (Overflow !== 1'b1) $display("[TB] FAIL ovf_add_max: got %b expected 1", Overflow);
        else passCount++;
`endif
        tick();
        for (int op = 0; op < 8; op++) begin
            applyStimulus(2'd1, 2'd3, 3'(op), 2'd0, 1'b0, 1'b0);
            totalCount++;
            if (ALUResult !== sweepExp[op]) $display("[TB] FAIL sweep_op%0d: got %h expected %h", op, ALUResult, sweepExp[op]);
            else passCount++;
            totalCount++;
            if (Zero !== (sweepExp[op] == 32'h0)) $display("[TB] FAIL sweep_zero_op%0d: got %b expected %b", op, Zero, sweepExp[op] == 32'h0);
            else passCount++;
`ifdef DATAPATH_OVF_EN
            totalCount++;
            if (Overflow !== (op == 1)) $display("[TB] FAIL sweep_ovf_op%0d: got %b expected %b", op, Overflow, op == 1);
            else passCount++;
`endif
        end
    endtask

    // Random operations, writes and occasional resets against the reference model
    task automatic test_random();
        logic [1:0]  a1, a2, wa;
        logic [2:0]  op;
        logic        we, rst;
        logic [31:0] expResult;
        applyStimulus(2'd0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) model[i] = initVals[i];
        for (int n = 0; n < 300; n++) begin
            a1  = 2'($urandom_range(0, 3));
            a2  = 2'($urandom_range(0, 3));
            wa  = 2'($urandom_range(0, 3));
            op  = 3'($urandom_range(0, 7));
            we  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 24) == 0);
            applyStimulus(a1, a2, op, wa, we, rst);
            expResult = aluRef(op, model[a1], model[a2]);
            totalCount++;
            if (ReadData1 !== model[a1]) $display("[TB] FAIL rand_rd1 #%0d: got %h expected %h", n, ReadData1, model[a1]);
            else passCount++;
            totalCount++;
            if (ReadData2 !== model[a2]) $display("[TB] FAIL rand_rd2 #%0d: got %h expected %h", n, ReadData2, model[a2]);
            else passCount++;
            totalCount++;
            if (ALUResult !== expResult) $display("[TB] FAIL rand_alu #%0d op%0d: got %h expected %h", n, op, ALUResult, expResult);
            else passCount++;
            totalCount++;
            if (Zero !== (expResult == 32'h0)) $display("[TB] FAIL rand_zero #%0d: got %b expected %b", n, Zero, expResult == 32'h0);
            else passCount++;
`ifdef DATAPATH_OVF_EN
            totalCount++;
            if (Overflow !== ovfRef(op, model[a1], model[a2])) $display("[TB] FAIL rand_ovf #%0d: got %b expected %b", n, Overflow, ovfRef(op, model[a1], model[a2]));
            else passCount++;
`endif
            tick();
            if (rst) begin
                for (int i = 0; i < 4; i++) model[i] = initVals[i];
            end else if (we) begin
                model[wa] = expResult;
            end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        #1;
        test_reset();
        test_xor_write();
        test_add_sub_chain();
        test_reset_priority();
        test_opcode_sweep();
        test_random();
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
